// File: rtl/tlk2711_pkg.sv
// Shared types and constants for the TLK2711 transmit DMA command scheduler.
package tlk2711_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_DRAIN,
    S_DONE,
    S_ABORT
  } state_e;

  // DataMover MM2S command word (72 bits).
  typedef struct packed {
    logic [3:0]  rsvd;
    logic [3:0]  tag;
    logic [31:0] saddr;
    logic        drr;
    logic        eof;
    logic [5:0]  dsa;
    logic        incr;
    logic [22:0] btt;
  } dm_cmd_t;

  typedef struct packed {
    logic       okay;
    logic       slverr;
    logic       decerr;
    logic       interr;
    logic [3:0] tag;
  } dm_sts_t;

  localparam logic [3:0] E_ZERO_LEN = 4'hE;
  localparam logic [3:0] E_TAG      = 4'hF;

endpackage

// File: rtl/tlk2711_credit_cnt.sv
// Outstanding-command counter: +1 per accepted command, -1 per status, never underflows.
module tlk2711_credit_cnt #(
  parameter int MAX_OUTSTANDING = 4,
  parameter int W               = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_clr,
  input  logic         i_inc,
  input  logic         i_dec,
  output logic [W-1:0] o_cnt,
  output logic         o_full,
  output logic         o_empty
);

  logic [W-1:0] r_cnt;
  logic         w_dec;

  assign w_dec = i_dec && (r_cnt != '0);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)              r_cnt <= '0;
    else if (i_clr)            r_cnt <= '0;
    else if (i_inc && !w_dec)  r_cnt <= r_cnt + W'(1);
    else if (!i_inc && w_dec)  r_cnt <= r_cnt - W'(1);
  end

  assign o_cnt   = r_cnt;
  assign o_full  = (r_cnt == W'(MAX_OUTSTANDING));
  assign o_empty = (r_cnt == '0);

endmodule

// File: rtl/tlk2711_tx_dma_sched.sv
// Issues one DataMover read command per packet of a TLK2711 TX burst with bounded
// outstanding commands, checks returned statuses in tag order, reports progress.
module tlk2711_tx_dma_sched
  import tlk2711_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 4,
  parameter int CNT_W           = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_soft_rst,
  input  logic             i_start,
  input  logic [31:0]      i_base_addr,
  input  logic [31:0]      i_stride,
  input  logic [22:0]      i_pkt_len,
  input  logic [CNT_W-1:0] i_pkt_num,
  output logic [71:0]      o_dma_rdcmd_data,
  output logic             o_dma_rdcmd_valid,
  input  logic             i_dma_rdcmd_ready,
  input  logic [7:0]       i_dma_sts_data,
  input  logic             i_dma_sts_valid,
  output logic             o_dma_sts_ready,
  output logic             o_pkt_issued,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_err,
  output logic [3:0]       o_err_code,
  output logic [CNT_W-1:0] o_pkt_cnt
);

  localparam int OW = $clog2(MAX_OUTSTANDING + 1);

  state_e           r_state, w_state_nxt;
  logic [31:0]      r_addr, r_stride;
  logic [22:0]      r_len;
  logic [CNT_W-1:0] r_num, r_issued, r_pkt_cnt;
  logic [3:0]       r_tag, r_exp_tag, r_err_code;
  logic             r_err, r_done, r_pkt_issued;
  logic [OW-1:0]    w_out_cnt;
  logic             w_full, w_empty;
  logic             w_cmd_vld, w_hs, w_start, w_sts_good, w_sts_bad, w_drained;
  dm_sts_t          w_sts;
  dm_cmd_t          w_cmd;

  assign w_sts      = i_dma_sts_data;
  assign w_start    = i_start && (r_state == S_IDLE);
  assign w_hs       = w_cmd_vld && i_dma_rdcmd_ready;
  assign w_sts_good = i_dma_sts_valid && !w_empty && w_sts.okay && (w_sts.tag == r_exp_tag);
  assign w_sts_bad  = i_dma_sts_valid && !w_sts_good;
  // Outstanding reaches zero at this edge (lets o_done follow the last status by one cycle).
  assign w_drained  = !w_hs && (w_empty || ((w_out_cnt == OW'(1)) && i_dma_sts_valid));

  tlk2711_credit_cnt #(.MAX_OUTSTANDING(MAX_OUTSTANDING), .W(OW)) u_credit (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_clr   (i_soft_rst),
    .i_inc   (w_hs),
    .i_dec   (i_dma_sts_valid),
    .o_cnt   (w_out_cnt),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)        r_state <= S_IDLE;
    else if (i_soft_rst) r_state <= S_IDLE;
    else                 r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_start && (i_pkt_num != '0) && (i_pkt_len != '0)) w_state_nxt = S_ISSUE;
      S_ISSUE: begin
        if (w_sts_bad)                           w_state_nxt = S_ABORT;
        else if ((r_issued == r_num) && w_drained) w_state_nxt = S_DONE;
        else if (r_issued == r_num)              w_state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        if (w_sts_bad)      w_state_nxt = S_ABORT;
        else if (w_drained) w_state_nxt = S_DONE;
      end
      S_DONE:  w_state_nxt = S_IDLE;
      S_ABORT: if (w_drained) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_cmd             = '{rsvd: 4'd0, tag: r_tag, saddr: r_addr, drr: 1'b0, eof: 1'b1,
                          dsa: 6'd0, incr: 1'b1, btt: r_len};
    w_cmd_vld         = (r_state == S_ISSUE) && (r_issued < r_num) && !w_full;
    o_dma_rdcmd_valid = w_cmd_vld;
    o_dma_rdcmd_data  = w_cmd_vld ? w_cmd : '0;
    o_busy            = (r_state != S_IDLE);
    o_dma_sts_ready   = 1'b1;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n || i_soft_rst) begin
      r_addr <= '0; r_stride <= '0; r_len <= '0; r_num <= '0; r_issued <= '0;
      r_tag <= '0; r_exp_tag <= '0; r_pkt_cnt <= '0; r_err <= 1'b0; r_err_code <= '0;
      r_done <= 1'b0; r_pkt_issued <= 1'b0;
    end else begin
      r_pkt_issued <= w_hs;
      r_done       <= (w_state_nxt == S_DONE) || (w_start && (i_pkt_num == '0));
      if (w_start) begin
        r_addr     <= i_base_addr;
        r_stride   <= i_stride;
        r_len      <= i_pkt_len;
        r_num      <= i_pkt_num;
        r_issued   <= '0;
        r_tag      <= '0;
        r_exp_tag  <= '0;
        r_pkt_cnt  <= '0;
        r_err      <= (i_pkt_num != '0) && (i_pkt_len == '0);
        r_err_code <= ((i_pkt_num != '0) && (i_pkt_len == '0)) ? E_ZERO_LEN : 4'd0;
      end
      if (w_hs) begin
        r_addr   <= r_addr + r_stride;
        r_issued <= r_issued + CNT_W'(1);
        r_tag    <= r_tag + 4'd1;
      end
      if (w_sts_good) begin
        r_pkt_cnt <= r_pkt_cnt + CNT_W'(1);
        r_exp_tag <= r_exp_tag + 4'd1;
      end else if (w_sts_bad && (!r_err || w_start)) begin
        // Spurious or out-of-order status reports as a tag fault; others keep the DMA's error bits.
        r_err      <= 1'b1;
        r_err_code <= (w_empty || w_sts.okay) ? E_TAG
                    : {w_sts.okay, w_sts.slverr, w_sts.decerr, w_sts.interr};
      end
    end
  end

  assign o_pkt_issued = r_pkt_issued;
  assign o_done       = r_done;
  assign o_err        = r_err;
  assign o_err_code   = r_err_code;
  assign o_pkt_cnt    = r_pkt_cnt;

endmodule

// File: tb/tb_tlk2711_tx_dma_sched.sv
// Directed + randomized bench for tlk2711_tx_dma_sched against a packet-index command model.
module tb_tlk2711_tx_dma_sched;

  localparam int MAXO  = 4;
  localparam int CNT_W = 16;

  logic             i_clk = 1'b0;
  logic             i_rst_n, i_soft_rst, i_start;
  logic [31:0]      i_base_addr, i_stride;
  logic [22:0]      i_pkt_len;
  logic [CNT_W-1:0] i_pkt_num;
  logic [71:0]      o_dma_rdcmd_data;
  logic             o_dma_rdcmd_valid, i_dma_rdcmd_ready;
  logic [7:0]       i_dma_sts_data;
  logic             i_dma_sts_valid, o_dma_sts_ready;
  logic             o_pkt_issued, o_busy, o_done, o_err;
  logic [3:0]       o_err_code;
  logic [CNT_W-1:0] o_pkt_cnt;

  int          n_vec = 0, n_err = 0;
  int          n_done = 0, n_iss = 0;
  logic [71:0] cmd_log[$];

  always #5 i_clk = ~i_clk;

  tlk2711_tx_dma_sched #(.MAX_OUTSTANDING(MAXO), .CNT_W(CNT_W)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_soft_rst(i_soft_rst), .i_start(i_start),
    .i_base_addr(i_base_addr), .i_stride(i_stride), .i_pkt_len(i_pkt_len),
    .i_pkt_num(i_pkt_num), .o_dma_rdcmd_data(o_dma_rdcmd_data),
    .o_dma_rdcmd_valid(o_dma_rdcmd_valid), .i_dma_rdcmd_ready(i_dma_rdcmd_ready),
    .i_dma_sts_data(i_dma_sts_data), .i_dma_sts_valid(i_dma_sts_valid),
    .o_dma_sts_ready(o_dma_sts_ready), .o_pkt_issued(o_pkt_issued), .o_busy(o_busy),
    .o_done(o_done), .o_err(o_err), .o_err_code(o_err_code), .o_pkt_cnt(o_pkt_cnt)
  );

  // DMA-side observer: log accepted commands, count pulses.
  always @(posedge i_clk) begin
    if (i_rst_n && o_dma_rdcmd_valid && i_dma_rdcmd_ready) cmd_log.push_back(o_dma_rdcmd_data);
    if (o_done)       n_done++;
    if (o_pkt_issued) n_iss++;
  end

  task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Packet i reads base + i*stride (mod 2^32) with tag i mod 16.
  function automatic logic [71:0] exp_cmd(input logic [31:0] b, input logic [31:0] s,
                                          input logic [22:0] l, input int idx);
    logic [31:0] i32, a;
    logic [3:0]  t;
    i32 = idx;
    a   = b + s * i32;
    t   = i32[3:0];
    return {4'd0, t, a, 1'b0, 1'b1, 6'd0, 1'b1, l};
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge i_clk);
  endtask

  task automatic start_run(input logic [31:0] b, input logic [31:0] s,
                           input logic [22:0] l, input int n);
    @(negedge i_clk);
    i_base_addr = b; i_stride = s; i_pkt_len = l; i_pkt_num = CNT_W'(n); i_start = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
  endtask

  task automatic sts(input logic [7:0] d);
    @(negedge i_clk);
    i_dma_sts_valid = 1'b1; i_dma_sts_data = d;
    @(negedge i_clk);
    i_dma_sts_valid = 1'b0; i_dma_sts_data = 8'h00;
  endtask

  task automatic check_cmds(input string tag, input int c0, input logic [31:0] b,
                            input logic [31:0] s, input logic [22:0] l, input int n);
    check({tag, "_count"}, cmd_log.size() - c0, n);
    for (int k = 0; k < n && (c0 + k) < cmd_log.size(); k++)
      check({tag, "_cmd"}, cmd_log[c0 + k], exp_cmd(b, s, l, k));
  endtask

  initial begin
    int          c0, d0, i0, na, sent, cyc, maxo, outst, rn;
    logic        pv, pr;
    logic [71:0] pd, c1;
    logic [31:0] rb, rs;
    logic [22:0] rl;

    i_rst_n = 1'b0; i_soft_rst = 1'b0; i_start = 1'b0; i_base_addr = '0; i_stride = '0;
    i_pkt_len = '0; i_pkt_num = '0; i_dma_rdcmd_ready = 1'b1; i_dma_sts_data = '0;
    i_dma_sts_valid = 1'b0;
    tick(2);
    check("rst_valid", o_dma_rdcmd_valid, 0);
    check("rst_data", o_dma_rdcmd_data, 0);
    check("rst_busy", o_busy, 0);
    check("rst_done_err", {o_done, o_err, o_pkt_issued}, 0);
    check("rst_code_cnt", {o_err_code, o_pkt_cnt}, 0);
    i_rst_n = 1'b1;

    // Basic three-packet run.
    c0 = cmd_log.size(); d0 = n_done; i0 = n_iss;
    start_run(32'h1000_0000, 32'h800, 23'h400, 3);
    check("first_valid_lat", o_dma_rdcmd_valid, 1);
    tick(4);
    check_cmds("basic", c0, 32'h1000_0000, 32'h800, 23'h400, 3);
    c1 = cmd_log[c0 + 2];
    check("basic_addr2", c1[63:32], 32'h1000_1000);
    sts(8'h80); sts(8'h81); sts(8'h82);
    check("done_lat", o_done, 1);
    tick(2);
    check("basic_pkt_cnt", o_pkt_cnt, 3);
    check("basic_err", o_err, 0);
    check("basic_done_cnt", n_done - d0, 1);
    check("basic_issued_pulses", n_iss - i0, 3);

    // Credit limit, with a start pulse while busy that must be ignored.
    c0 = cmd_log.size(); d0 = n_done;
    start_run(32'h2000_0000, 32'h100, 23'h80, 8);
    tick(10);
    check("credit_count", cmd_log.size() - c0, MAXO);
    check("credit_valid_low", o_dma_rdcmd_valid, 0);
    start_run(32'h0, 32'h4, 23'h1, 1);
    for (int k = 0; k < 8; k++) begin
      sts({4'h8, 4'(k)});
      tick(2);
      check("credit_release", cmd_log.size() - c0, (MAXO + 1 + k > 8) ? 8 : MAXO + 1 + k);
    end
    check_cmds("credit", c0, 32'h2000_0000, 32'h100, 23'h80, 8);
    check("credit_pkt_cnt", o_pkt_cnt, 8);
    check("credit_done", n_done - d0, 1);

    // Backpressure: command must hold while ready is low.
    c0 = cmd_log.size(); d0 = n_done; i0 = n_iss;
    i_dma_rdcmd_ready = 1'b0;
    start_run(32'h3000_0000, 32'h40, 23'h20, 2);
    for (int k = 0; k < 5; k++) begin
      check("bp_valid", o_dma_rdcmd_valid, 1);
      check("bp_data", o_dma_rdcmd_data, exp_cmd(32'h3000_0000, 32'h40, 23'h20, 0));
      tick(1);
    end
    check("bp_no_cmd", cmd_log.size() - c0, 0);
    check("bp_no_pulse", n_iss - i0, 0);
    i_dma_rdcmd_ready = 1'b1;
    tick(3);
    check_cmds("bp", c0, 32'h3000_0000, 32'h40, 23'h20, 2);
    check("bp_pulses", n_iss - i0, 2);
    sts(8'h80); sts(8'h81);
    tick(2);
    check("bp_done", n_done - d0, 1);

    // Error abort on a SLVERR status.
    c0 = cmd_log.size(); d0 = n_done;
    start_run(32'h4000_0000, 32'h1000, 23'h200, 6);
    tick(6);
    check("abort_pre_count", cmd_log.size() - c0, MAXO);
    sts(8'h80);
    sts(8'h42);
    na = cmd_log.size();
    check("abort_issued", na - c0, 5);
    check("abort_err", {o_err, o_err_code}, {1'b1, 4'h4});
    tick(4);
    check("abort_no_more_cmd", cmd_log.size(), na);
    check("abort_valid_low", o_dma_rdcmd_valid, 0);
    check("abort_busy_drain", o_busy, 1);
    for (int k = 2; k < na - c0; k++) begin
      c1 = cmd_log[c0 + k];
      sts({4'h8, c1[67:64]});
    end
    tick(2);
    check("abort_idle", o_busy, 0);
    check("abort_err_final", {o_err, o_err_code}, {1'b1, 4'h4});
    check("abort_pkt_cnt", o_pkt_cnt, 1);
    check("abort_no_done", n_done - d0, 0);

    // num = 0: done without a command.
    c0 = cmd_log.size(); d0 = n_done;
    start_run(32'h5000_0000, 32'h10, 23'h100, 0);
    check("zero_num_done", {o_done, o_busy, o_err}, 3'b100);
    tick(3);
    check("zero_num_cmds", cmd_log.size() - c0, 0);
    check("zero_num_done_cnt", n_done - d0, 1);

    // len = 0: error, no command.
    c0 = cmd_log.size();
    start_run(32'h5000_0000, 32'h10, 23'h0, 4);
    check("zero_len_err", {o_err, o_err_code, o_busy}, {1'b1, 4'hE, 1'b0});
    tick(3);
    check("zero_len_cmds", cmd_log.size() - c0, 0);

    // Address wrap past 2^32.
    c0 = cmd_log.size(); d0 = n_done;
    start_run(32'hFFFF_FC00, 32'h800, 23'h10, 2);
    check("wrap_err_cleared", o_err, 0);
    tick(4);
    check_cmds("wrap", c0, 32'hFFFF_FC00, 32'h800, 23'h10, 2);
    c1 = cmd_log[c0 + 1];
    check("wrap_addr1", c1[63:32], 32'h0000_0400);
    sts(8'h80); sts(8'h81);
    tick(2);
    check("wrap_done", n_done - d0, 1);

    // Status with nothing outstanding.
    sts(8'h80);
    check("spurious_err", {o_err, o_err_code, o_busy}, {1'b1, 4'hF, 1'b0});
    check("spurious_pkt_cnt", o_pkt_cnt, 2);

    // Async reset mid-issue, then a clean restart from tag 0.
    start_run(32'h5000_0000, 32'h100, 23'h40, 8);
    tick(2);
    #2 i_rst_n = 1'b0;
    #1;
    check("arst_valid_busy", {o_dma_rdcmd_valid, o_busy}, 0);
    check("arst_data", o_dma_rdcmd_data, 0);
    check("arst_flags", {o_err, o_err_code, o_pkt_cnt, o_done, o_pkt_issued}, 0);
    tick(2);
    i_rst_n = 1'b1;
    c0 = cmd_log.size(); d0 = n_done;
    start_run(32'h6000_0000, 32'h20, 23'h8, 2);
    tick(3);
    check_cmds("post_rst", c0, 32'h6000_0000, 32'h20, 23'h8, 2);
    sts(8'h80); sts(8'h81);
    tick(2);
    check("post_rst_done", {o_pkt_cnt, o_err}, {16'd2, 1'b0});
    check("post_rst_done_cnt", n_done - d0, 1);

    // Soft reset with commands outstanding.
    start_run(32'h7000_0000, 32'h20, 23'h8, 4);
    tick(6);
    @(negedge i_clk) i_soft_rst = 1'b1;
    @(negedge i_clk) i_soft_rst = 1'b0;
    check("srst_state", {o_busy, o_dma_rdcmd_valid, o_pkt_cnt}, 0);
    c0 = cmd_log.size(); d0 = n_done;
    start_run(32'h7100_0000, 32'h20, 23'h8, 1);
    tick(2);
    check_cmds("post_srst", c0, 32'h7100_0000, 32'h20, 23'h8, 1);
    sts(8'h80);
    tick(2);
    check("post_srst_done", {o_pkt_cnt, o_err, o_busy}, {16'd1, 1'b0, 1'b0});

    // Randomized runs: random ready and status timing, in-order OKAY statuses.
    for (int r = 0; r < 4; r++) begin
      rb = $urandom; rs = $urandom; rl = 23'($urandom_range(1, 23'h7F_FFFF));
      rn = $urandom_range(1, 20);
      c0 = cmd_log.size(); d0 = n_done; i0 = n_iss;
      sent = 0; cyc = 0; maxo = 0; pv = 1'b0; pr = 1'b1; pd = '0;
      i_dma_rdcmd_ready = 1'b0;
      start_run(rb, rs, rl, rn);
      while ((o_busy || sent < rn) && cyc < 3000) begin
        outst = (cmd_log.size() - c0) - sent;
        if (outst > maxo) maxo = outst;
        if (pv && !pr) begin
          check("rnd_hold_valid", o_dma_rdcmd_valid, 1);
          check("rnd_hold_data", o_dma_rdcmd_data, pd);
        end
        pv = o_dma_rdcmd_valid; pd = o_dma_rdcmd_data;
        i_dma_rdcmd_ready = 1'($urandom_range(0, 1));
        pr = i_dma_rdcmd_ready;
        if (sent < cmd_log.size() - c0 && $urandom_range(0, 2) == 0) begin
          c1 = cmd_log[c0 + sent];
          i_dma_sts_valid = 1'b1; i_dma_sts_data = {4'h8, c1[67:64]};
          sent++;
        end else begin
          i_dma_sts_valid = 1'b0; i_dma_sts_data = 8'h00;
        end
        @(negedge i_clk);
        cyc++;
      end
      i_dma_sts_valid = 1'b0; i_dma_rdcmd_ready = 1'b1;
      check("rnd_finished", o_busy, 0);
      check_cmds("rnd", c0, rb, rs, rl, rn);
      check("rnd_pkt_cnt", o_pkt_cnt, rn);
      check("rnd_err", o_err, 0);
      check("rnd_done", n_done - d0, 1);
      check("rnd_pulses", n_iss - i0, rn);
      check("rnd_credit_bound", (maxo <= MAXO) && (maxo > 0), 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/tlk2711_tx_dma_sched.md
Name: tlk2711_tx_dma_sched

Overview:
- Sequences MM2S DMA read commands for a multi-packet TLK2711 transmit burst.
- CPU-side logic supplies a base DDR address, packet count, packet length and address stride, then pulses start.
- The block issues one 72-bit DataMover command per packet, with a bounded number outstanding, and checks each returned status.
- Reports busy, done, error and progress back to the register file.

Parameters:
- MAX_OUTSTANDING, 4, maximum commands accepted by the DMA but not yet statused (1..15).
- CNT_W, 16, width of the packet count and packet counters.

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  asynchronous active-low reset.
- i_soft_rst  in  1  synchronous soft reset, same effect as reset.
- i_start  in  1  start pulse; only honoured in IDLE.
- i_base_addr  in  32  DDR address of packet 0.
- i_stride  in  32  byte increment between packets.
- i_pkt_len  in  23  bytes per packet (BTT).
- i_pkt_num  in  CNT_W  number of packets.
- o_dma_rdcmd_data  out  72  DataMover command.
- o_dma_rdcmd_valid  out  1  command valid.
- i_dma_rdcmd_ready  in  1  command ready.
- i_dma_sts_data  in  8  status: [7] OKAY, [6] SLVERR, [5] DECERR, [4] INTERR, [3:0] TAG.
- i_dma_sts_valid  in  1  status valid.
- o_dma_sts_ready  out  1  status ready; tied high.
- o_pkt_issued  out  1  pulse per accepted command.
- o_busy  out  1  high outside IDLE.
- o_done  out  1  one-cycle pulse on successful completion.
- o_err  out  1  sticky error flag; cleared by the next accepted start.
- o_err_code  out  4  captured status bits [7:4] of the first bad status, or 4'hF for a tag mismatch.
- o_pkt_cnt  out  CNT_W  packets whose status has completed.

Behaviour:
- Reset (async or soft): all outputs 0, state IDLE, counters 0.
- Command format: {4'd0, tag[3:0], addr[31:0], 1'b0 DRR, 1'b1 EOF, 6'd0 DSA, 1'b1 INCR, len[22:0]}.
  - tag = issue index mod 16.
- States:
  - IDLE:
    - On i_start: latch config, clear o_err/o_err_code/o_pkt_cnt.
    - If i_pkt_num==0: o_done pulse next cycle, stay IDLE.
    - If i_pkt_len==0: set o_err, o_err_code=4'hE, stay IDLE, issue nothing.
    - Otherwise go to ISSUE.
  - ISSUE:
    - Drive o_dma_rdcmd_valid while issued<num and outstanding<MAX_OUTSTANDING.
    - Data and valid are stable until ready (AXI-S rules).
    - On handshake: issued++, outstanding++, addr += stride (mod 2^32, wraps silently), o_pkt_issued pulse.
    - Back-to-back issue every cycle is allowed while credit remains.
    - When issued==num, go to DRAIN.
  - DRAIN: wait for outstanding==0, then go to DONE.
  - DONE: o_done pulse for one cycle, then go to IDLE.
  - ABORT: entered on any bad status.
    - Deassert valid at the next cycle boundary, after completing any handshake in progress.
    - Keep consuming statuses until outstanding==0, then go to IDLE with o_err=1 and no o_done.
- Status handling (any state, i_dma_sts_valid):
  - outstanding--.
  - If OKAY==1 and TAG==expected tag: o_pkt_cnt++ and expected tag++.
  - Otherwise go to ABORT and capture o_err_code for the first error only.
- Simultaneous command handshake and status in the same cycle: outstanding stays unchanged (+1 -1).
- A status arriving with outstanding==0 is a spurious status: o_err=1, o_err_code=4'hF; the counter does not underflow.
- i_start while busy: ignored.
- Reset mid-operation: abandons all counters; DMA-side recovery is the CPU's job.
- Latency: first valid is asserted 1 cycle after the accepted start; o_done is asserted 1 cycle after the final status.

Decomposition:
- Package tlk2711_pkg holds:
  - state enum (IDLE, ISSUE, DRAIN, DONE, ABORT);
  - dm_cmd_t packed struct (72 bits);
  - dm_sts_t packed struct (8 bits);
  - error code constants (E_ZERO_LEN=4'hE, E_TAG=4'hF).
- One sub-module, tlk2711_credit_cnt: up/down outstanding counter with full/empty flags, parameterised by MAX_OUTSTANDING.

Test Plan:
- Basic run: base=0x1000_0000, stride=0x800, len=0x400, num=3, ready always high, OKAY statuses with tags 0,1,2.
  - Expect 3 commands with addresses 0x1000_0000/0x1000_0800/0x1000_1000, BTT=0x400, EOF=1.
  - Expect o_pkt_cnt=3, one o_done pulse, o_err=0.
- Credit limit: MAX_OUTSTANDING=4, num=8, statuses withheld.
  - Expect exactly 4 commands, then valid low.
  - Each returned status releases exactly one further command.
- Backpressure: ready low for 5 cycles during a valid command.
  - Expect data and valid stable throughout; no duplicate command; o_pkt_issued pulses once.
- Error abort: num=6, the second status has SLVERR (0x42).
  - Expect no further commands after the next cycle and remaining outstanding statuses drained.
  - Expect o_err=1, o_err_code=4'h4, o_pkt_cnt=1, no o_done.
- Edge cases:
  - num=0 gives o_done with no command.
  - len=0 gives o_err_code=4'hE with no command.
  - base=0xFFFF_FC00, stride=0x800 gives a second address of 0x0000_0400.
- Reset mid-run: assert i_rst_n low during ISSUE.
  - Expect all outputs 0 asynchronously; a following start runs cleanly from tag 0.
